// File: rtl/growl_pkg.sv
// Shared definitions for the growl core front end: fetch FSM states and
// the opcode patterns that mark two-word instructions.
package growl_pkg;

    typedef enum logic [2:0] {
        W1_REQ,
        W1_WAIT,
        W2_REQ,
        W2_WAIT,
        HOLD
    } fetch_state_t;

    // LDS/STS and JMP/CALL carry a second 16-bit word
    localparam logic [15:0] TW_LDS_MASK = 16'hFC0F;
    localparam logic [15:0] TW_LDS_VAL  = 16'h9000;
    localparam logic [15:0] TW_JMP_MASK = 16'hFE0C;
    localparam logic [15:0] TW_JMP_VAL  = 16'h940C;

endpackage

// File: rtl/twoword_detect.sv
// Flags an opcode word whose instruction occupies two program words.
// Purely combinational so decode can reuse it directly.
module twoword_detect
    import growl_pkg::*;
(
    input  logic [15:0] word,
    output logic        two_word
);

    assign two_word = ((word & TW_LDS_MASK) == TW_LDS_VAL) ||
                      ((word & TW_JMP_MASK) == TW_JMP_VAL);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one or two words per instruction
// with one request outstanding, and holds the result until downstream takes it.
module fetch_unit
    import growl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst_out,
    output logic [15:0] inst2_out,
    output logic [15:0] pc_out,
    output logic        two_word,
    output logic        valid_out,
    input  logic        ready_in
);

    fetch_state_t state, state_next;
    logic [15:0]  pc, pc_next, w1_q;
    logic         drop, drop_next;
    logic         is_two, in_req;
    logic         ld_w1, ld_one, ld_two, clr_valid;

    twoword_detect u_tw (
        .word     (imem_rdata),
        .two_word (is_two)
    );

    // A redirect cancels the request that would otherwise issue this cycle,
    // so an outstanding request can only exist in the WAIT states.
    assign imem_req = in_req & ~redirect & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= W1_REQ;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        drop_next  = drop;
        ld_w1      = 1'b0;
        ld_one     = 1'b0;
        ld_two     = 1'b0;
        clr_valid  = 1'b0;
        in_req     = 1'b0;
        imem_addr  = pc;
        case (state)
            W1_REQ: begin
                in_req     = 1'b1;
                state_next = W1_WAIT;
            end
            W1_WAIT: begin
                if (imem_valid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = W1_REQ;
                    end else if (is_two) begin
                        ld_w1      = 1'b1;
                        state_next = W2_REQ;
                    end else begin
                        ld_one     = 1'b1;
                        pc_next    = pc + 16'd1;
                        state_next = HOLD;
                    end
                end
            end
            W2_REQ: begin
                in_req     = 1'b1;
                imem_addr  = pc + 16'd1;
                state_next = W2_WAIT;
            end
            W2_WAIT: begin
                if (imem_valid) begin
                    ld_two     = 1'b1;
                    pc_next    = pc + 16'd2;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready_in) begin
                    clr_valid  = 1'b1;
                    state_next = W1_REQ;
                end
            end
            default: state_next = W1_REQ;
        endcase

        // Redirect wins; an in-flight response must be swallowed before refetching.
        if (redirect) begin
            pc_next   = redirect_pc;
            ld_w1     = 1'b0;
            ld_one    = 1'b0;
            ld_two    = 1'b0;
            clr_valid = 1'b1;
            if ((state == W1_WAIT || state == W2_WAIT) && !imem_valid) begin
                drop_next  = 1'b1;
                state_next = W1_WAIT;
            end else begin
                drop_next  = 1'b0;
                state_next = W1_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            inst_out  <= '0;
            inst2_out <= '0;
            pc_out    <= '0;
            two_word  <= 1'b0;
            w1_q      <= '0;
        end else begin
            if (ld_w1)
                w1_q <= imem_rdata;
            if (ld_one) begin
                inst_out  <= imem_rdata;
                inst2_out <= '0;
                two_word  <= 1'b0;
                pc_out    <= pc;
                valid_out <= 1'b1;
            end else if (ld_two) begin
                inst_out  <= w1_q;
                inst2_out <= imem_rdata;
                two_word  <= 1'b1;
                pc_out    <= pc;
                valid_out <= 1'b1;
            end else if (clr_valid) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with variable latency,
// scoreboard of expected accepted instructions, plus timed corner sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] inst_out, inst2_out, pc_out;
    logic        two_word, valid_out;
    logic        ready_in = 1'b1;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_out    (inst_out),
        .inst2_out   (inst2_out),
        .pc_out      (pc_out),
        .two_word    (two_word),
        .valid_out   (valid_out),
        .ready_in    (ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] w1;
        logic [15:0] w2;
        logic        two;
    } vec_t;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] inst2;
        logic [15:0] pc;
        logic        two;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [15:0] mem [logic [15:0]];
    int          lat = 1;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [15:0] raddr = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] rd(logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic push(logic [15:0] i1, logic [15:0] i2, logic [15:0] p, logic t);
        exp_t e;
        e.inst = i1; e.inst2 = i2; e.pc = p; e.two = t;
        sb.push_back(e);
    endtask

    // Memory model: answers each request lat cycles later, flags overlap
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = rd(raddr);
                busy = 1'b0;
            end
        end
        if (rst_n && imem_req) begin
            chk("one_outstanding", {31'd0, busy}, 32'd0);
            busy  = 1'b1;
            cnt   = lat;
            raddr = imem_addr;
        end
    end

    // Scoreboard: every accepted instruction must match the next expectation
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in && !redirect) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL accept_unexpected actual_pc=%h required=none", pc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc_inst",  {16'd0, inst_out},  {16'd0, e.inst});
                chk("acc_inst2", {16'd0, inst2_out}, {16'd0, e.inst2});
                chk("acc_pc",    {16'd0, pc_out},    {16'd0, e.pc});
                chk("acc_two",   {31'd0, two_word},  {31'd0, e.two});
            end
        end
    end

    task automatic wait_accept(string name);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = valid_out && ready_in && !redirect;
        end
        chk(name, {31'd0, got}, 32'd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{16'd0,  16'h0C01, 16'h0000, 1'b0};
        tbl[1] = '{16'd1,  16'h9000, 16'h1234, 1'b1};
        tbl[2] = '{16'd3,  16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{16'd4,  16'h940C, 16'h0100, 1'b1};
        tbl[4] = '{16'd6,  16'h940E, 16'h0ABC, 1'b1};
        tbl[5] = '{16'd8,  16'h9001, 16'h0000, 1'b0};
        tbl[6] = '{16'd9,  16'h9200, 16'h5555, 1'b1};
        tbl[7] = '{16'd11, 16'h940D, 16'h0001, 1'b1};
        tbl[8] = '{16'd13, 16'h9408, 16'h0000, 1'b0};
        for (int i = 0; i < 9; i++) begin
            mem[tbl[i].addr] = tbl[i].w1;
            if (tbl[i].two) mem[tbl[i].addr + 16'd1] = tbl[i].w2;
            push(tbl[i].w1, tbl[i].two ? tbl[i].w2 : 16'h0000, tbl[i].addr, tbl[i].two);
        end
        mem[16'd14]   = 16'hE0A5;
        mem[16'd15]   = 16'hFFFF;
        mem[16'h0040] = 16'h2411;
        mem[16'h0041] = 16'h9000;
        mem[16'h0042] = 16'hBEEF;
        mem[16'h0080] = 16'h0C22;
        mem[16'hFFFF] = 16'h0C33;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_inst",  {16'd0, inst_out},  32'd0);
        chk("rst_inst2", {16'd0, inst2_out}, 32'd0);
        chk("rst_pc",    {16'd0, pc_out},    32'd0);
        chk("rst_two",   {31'd0, two_word},  32'd0);
        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_addr",  {16'd0, imem_addr}, 32'd0);

        // First instruction timing: REQ, WAIT, HOLD
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("c1_req",  {31'd0, imem_req},  32'd1);
        chk("c1_addr", {16'd0, imem_addr}, 32'd0);
        @(negedge clk);
        chk("c2_req",   {31'd0, imem_req},  32'd0);
        chk("c2_valid", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        chk("c3_valid", {31'd0, valid_out}, 32'd1);
        chk("c3_inst",  {16'd0, inst_out},  32'h0C01);
        @(negedge clk);
        chk("c4_req",  {31'd0, imem_req},  32'd1);
        chk("c4_addr", {16'd0, imem_addr}, 32'd1);

        // Drain the table through the scoreboard
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("table_drain", sb.size(), 32'd0);

        // Hold with ready_in low
        next_cycle();
        ready_in = 1'b0;
        push(16'hE0A5, 16'h0000, 16'd14, 1'b0);
        for (int i = 0; i < 40 && !valid_out; i++) @(negedge clk);
        chk("hold_valid", {31'd0, valid_out}, 32'd1);
        lat = 3;
        for (int k = 0; k < 5; k++) begin
            chk("hold_inst",  {16'd0, inst_out},  32'hE0A5);
            chk("hold_pc",    {16'd0, pc_out},    32'd14);
            chk("hold_valid", {31'd0, valid_out}, 32'd1);
            chk("hold_noreq", {31'd0, imem_req},  32'd0);
            @(negedge clk);
        end
        next_cycle();
        ready_in = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rel_req",  {31'd0, imem_req},  32'd1);
        chk("rel_addr", {16'd0, imem_addr}, 32'd15);

        // Redirect in W1_WAIT with a slow response that must be dropped
        push(16'h2411, 16'h0000, 16'h0040, 1'b0);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        chk("rd1_req",   {31'd0, imem_req},  32'd0);
        chk("rd1_valid", {31'd0, valid_out}, 32'd0);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("rd2_req", {31'd0, imem_req}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rd3_req",   {31'd0, imem_req},  32'd0);
        chk("rd3_valid", {31'd0, valid_out}, 32'd0);
        next_cycle();
        lat = 1;
        @(negedge clk);
        chk("rd4_valid", {31'd0, valid_out}, 32'd0);
        chk("rd4_req",   {31'd0, imem_req},  32'd1);
        chk("rd4_addr",  {16'd0, imem_addr}, 32'h0040);
        wait_accept("acc_0040");

        // Redirect coincident with the second-word response
        push(16'h0C22, 16'h0000, 16'h0080, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("w2_req",  {31'd0, imem_req},  32'd1);
        chk("w2_addr", {16'd0, imem_addr}, 32'h0042);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("w2r_valid", {31'd0, valid_out}, 32'd0);
        chk("w2r_req",   {31'd0, imem_req},  32'd1);
        chk("w2r_addr",  {16'd0, imem_addr}, 32'h0080);
        wait_accept("acc_0080");

        // One-word instruction at 16'hFFFF wraps to 0
        push(16'h0C33, 16'h0000, 16'hFFFF, 1'b0);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("wr1_addr", {16'd0, imem_addr}, 32'hFFFF);
        wait_accept("acc_ffff");
        push(16'h0C01, 16'h0000, 16'h0000, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("wr1_next_req",  {31'd0, imem_req},  32'd1);
        chk("wr1_next_addr", {16'd0, imem_addr}, 32'h0000);
        mem[16'hFFFF] = 16'h940C;
        wait_accept("acc_0000");

        // Two-word instruction at 16'hFFFF: second word at 0, next fetch at 1
        push(16'h940C, 16'h0C01, 16'hFFFF, 1'b1);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("wr2_addr1", {16'd0, imem_addr}, 32'hFFFF);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("wr2_req2",  {31'd0, imem_req},  32'd1);
        chk("wr2_addr2", {16'd0, imem_addr}, 32'h0000);
        wait_accept("acc_ffff_two");
        next_cycle();
        ready_in = 1'b0;
        @(negedge clk);
        chk("wr2_next_req",  {31'd0, imem_req},  32'd1);
        chk("wr2_next_addr", {16'd0, imem_addr}, 32'h0001);

        repeat (6) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the growl AVR-style core, directly upstream of the execute stage. It owns the program counter and fetches 16-bit instruction words from instruction memory over a one-outstanding request/valid interface. It assembles one- or two-word instructions (LDS/STS/JMP/CALL) and holds each instruction in an output register until downstream accepts it. It redirects on taken branches using the execute stage's `branch_taken` and `pc_plus_offset`.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: word address fetched first after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  request a word at `imem_addr` this cycle.
- `imem_addr`  out  16  word address of the request.
- `imem_valid`  in  1  response strobe; at most one per request, ≥1 cycle after the request.
- `imem_rdata`  in  16  response word, sampled when `imem_valid`=1.
- `redirect`  in  1  taken branch; connects to execute `branch_taken` gated by branch-instruction valid.
- `redirect_pc`  in  16  target; connects to execute `pc_plus_offset`.
- `inst_out`  out  16  first instruction word; feeds execute `inst_in`.
- `inst2_out`  out  16  second word, 16'h0000 for one-word instructions.
- `pc_out`  out  16  word address of `inst_out`; feeds execute `pc_in`.
- `two_word`  out  1  held instruction is two words.
- `valid_out`  out  1  output register holds an instruction.
- `ready_in`  in  1  downstream accepts the instruction when `valid_out`&`ready_in`.

## Operation
- States: `W1_REQ`, `W1_WAIT`, `W2_REQ`, `W2_WAIT`, `HOLD`.
- `W1_REQ`: `imem_req`=1, `imem_addr`=`pc`. Go to `W1_WAIT`.
- `W1_WAIT`: on `imem_valid`, latch word 1.
  - If two-word, go to `W2_REQ`.
  - Otherwise load the output register (`inst2_out`=0, `two_word`=0, `pc_out`=`pc`), set `pc`+=1, and go to `HOLD`.
- Two-word detect (combinational on `imem_rdata`):
  - `(w & 16'hFC0F)==16'h9000` (LDS/STS), or
  - `(w & 16'hFE0C)==16'h940C` (JMP/CALL).
- `W2_REQ`: `imem_req`=1, `imem_addr`=`pc`+1. Go to `W2_WAIT`.
- `W2_WAIT`: on `imem_valid`, load the output register (`two_word`=1, `pc_out`=`pc`), set `pc`+=2, and go to `HOLD`.
- `HOLD`: `valid_out`=1. On `ready_in`, clear `valid_out` and go to `W1_REQ`.
- `imem_req` is asserted only in `*_REQ` states, for exactly one cycle per request. Never more than one request is outstanding.
- PC arithmetic is 16-bit modulo. `pc`+1 and `pc`+2 wrap: 16'hFFFF+1 → 16'h0000.
- Redirect has priority over every other event in the same cycle:
  - Set `pc` to `redirect_pc`, clear `valid_out`, and discard any partially assembled word 1.
  - If a request is outstanding (`W1_WAIT`/`W2_WAIT` without `imem_valid` this cycle), set `drop`=1 and go to `W1_WAIT`. The next `imem_valid` is discarded, `drop` is cleared, and the state goes to `W1_REQ`.
  - Otherwise (including `imem_valid` in the same cycle, whose data is discarded), go to `W1_REQ`.
  - Redirect in `HOLD` with `ready_in`=1: the instruction is not considered accepted.
  - A second redirect while `drop`=1 overwrites `pc` only.

## Timing
- Reset values:
  - `state`=`W1_REQ`, `pc`=`RESET_PC`, `drop`=0.
  - `valid_out`=0, `inst_out`=0, `inst2_out`=0, `pc_out`=0, `two_word`=0.
  - `imem_req`=0 while `rst_n`=0; `imem_addr`=`RESET_PC`.
- First `imem_req` occurs in the first cycle after `rst_n` deasserts.
- Reset mid-transaction: a late `imem_valid` arriving after reset is treated as the response to the new first request. The memory must also be reset.
- Outputs are registered. `valid_out` rises the cycle after the final `imem_valid`.
- Minimum latency with 1-cycle memory and `ready_in`=1:
  - one-word: 3 cycles per instruction (REQ, WAIT, HOLD).
  - two-word: 5 cycles per instruction.
- `inst_out`/`inst2_out`/`pc_out`/`two_word` are stable while `valid_out`=1 and `ready_in`=0.

## Structure
- Shared package `growl_pkg`:
  - `fetch_state_t` enum.
  - `TW_LDS_MASK`=16'hFC0F, `TW_LDS_VAL`=16'h9000.
  - `TW_JMP_MASK`=16'hFE0C, `TW_JMP_VAL`=16'h940C.
- One sub-module, `twoword_detect` (16-bit in, 1-bit out). Also reusable by decode.

## Test plan
- Reset, memory returns 16'h0C01 at addr 0 with 1-cycle latency, `ready_in`=1 → `imem_req` at cycle 1; `valid_out`=1 at cycle 3 with `inst_out`=16'h0C01, `pc_out`=0, `two_word`=0; next request at addr 1.
- Addr 4 = 16'h940C, addr 5 = 16'h0100 → `inst_out`=16'h940C, `inst2_out`=16'h0100, `two_word`=1, `pc_out`=4; next fetch at addr 6.
- Hold with `ready_in`=0 for 5 cycles → outputs unchanged and no `imem_req`; `ready_in`=1 → one request issued the next cycle.
- `redirect`=1 with `redirect_pc`=16'h0040 while in `W1_WAIT`, response arrives 3 cycles later → response discarded, `valid_out` stays 0; next `imem_addr`=16'h0040.
- `redirect` coincident with `imem_valid` in `W2_WAIT` → no `valid_out`; next request at `redirect_pc`; `drop`=0.
- `pc`=16'hFFFF with a one-word instruction → `pc_out`=16'hFFFF, then next `imem_addr`=16'h0000. A two-word instruction at 16'hFFFF → second request at 16'h0000, next fetch at 16'h0001.
